// File: rtl/game_level_fsm.sv
// game_level_fsm: level/round controller for the number-guessing game.
// Runs NUM_LEVELS difficulty levels, counts correct and wrong guesses per
// level, and drives the per-level limits and the countdown-timer preload.
//
// Ports:
//   clk, restart_n            clock, asynchronous active-low reset
//   start                     begin/restart a game (IDLE/WIN/GAMEOVER only)
//   confirm                   debounced button, rising edge detected here
//   guess_correct             comparator result, sampled on the confirm edge
//   timer                     current countdown value
//   level                     current level 0..NUM_LEVELS-1
//   max_incorrect, max_digit  per-level limits (combinational)
//   incorrect_cnt, round_cnt  wrong / correct guesses this level
//   timer_load, timer_init    one-cycle preload strobe and saturated value
//   playing, win, gameover    state flags
//   score                     running score (only when SCORE_EN is defined)
//
// Optional feature macro: SCORE_EN adds the score register and port.
module game_level_fsm #(
  parameter int unsigned NUM_LEVELS       = 3,
  parameter int unsigned ROUNDS_PER_LEVEL = 5,
  parameter int unsigned BASE_GUESSES     = 3,
  parameter int unsigned TIMER_BASE       = 30,
  parameter int unsigned TIMER_W          = 7
`ifdef SCORE_EN
  ,
  parameter int unsigned SCORE_W          = 10
`endif
) (
  input  logic               clk,
  input  logic               restart_n,
  input  logic               start,
  input  logic               confirm,
  input  logic               guess_correct,
  input  logic [TIMER_W-1:0] timer,
  output logic [2:0]         level,
  output logic [3:0]         max_incorrect,
  output logic [3:0]         max_digit,
  output logic [3:0]         incorrect_cnt,
  output logic [3:0]         round_cnt,
  output logic               timer_load,
  output logic [TIMER_W-1:0] timer_init,
  output logic               playing,
  output logic               win,
  output logic               gameover
`ifdef SCORE_EN
  ,
  output logic [SCORE_W-1:0] score
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_PLAY     = 3'd2;
  localparam logic [2:0] S_WIN      = 3'd3;
  localparam logic [2:0] S_GAMEOVER = 3'd4;

  localparam int unsigned LAST_LEVEL = NUM_LEVELS - 1;
  localparam int unsigned TIMER_MAX  = (32'd1 << TIMER_W) - 32'd1;

  logic [2:0] r_state, w_state_nxt;
  logic [2:0] r_level, w_level_nxt;
  logic [3:0] r_incorrect, w_incorrect_nxt;
  logic [3:0] r_round, w_round_nxt;
  logic       r_confirm_q;
  logic       r_timer_load;
  logic       w_conf_p;
  logic       w_new_game;
  logic [3:0] w_max_inc_play;
  logic [31:0] w_tinit_full;

`ifdef SCORE_EN
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic               w_score_inc;
  logic [31:0]        w_score_add;
  logic [31:0]        w_score_sum;
`endif

  // Single event per button press, however long it is held.
  assign w_conf_p       = confirm & ~r_confirm_q;
  assign w_max_inc_play = 4'(BASE_GUESSES + 32'(r_level));
  assign w_tinit_full   = TIMER_BASE * (32'(r_level) + 32'd1);

  // Limit outputs drop to zero once a game has ended.
  always_comb begin
    max_incorrect = 4'd0;
    max_digit     = 4'd0;
    if (r_state == S_IDLE || r_state == S_LOAD || r_state == S_PLAY) begin
      max_incorrect = w_max_inc_play;
      max_digit     = 4'(32'(r_level) + 32'd1);
    end
  end

  assign timer_init = (w_tinit_full > TIMER_MAX) ? TIMER_W'(TIMER_MAX)
                                                 : TIMER_W'(w_tinit_full);

  // Next-state, level, counter and score logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_level_nxt     = r_level;
    w_incorrect_nxt = r_incorrect;
    w_round_nxt     = r_round;
    w_new_game      = 1'b0;
`ifdef SCORE_EN
    w_score_nxt = r_score;
    w_score_inc = 1'b0;
    w_score_add = 32'(r_level) + 32'd1;
    w_score_sum = 32'd0;
`endif
    case (r_state)
      S_IDLE, S_WIN, S_GAMEOVER: begin
        if (start) w_new_game = 1'b1;
      end
      S_LOAD: begin
        w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        // Timeout takes priority over a simultaneous guess.
        if (timer == '0) begin
          w_state_nxt = S_GAMEOVER;
        end else if (w_conf_p && guess_correct) begin
          w_round_nxt = 4'(r_round + 4'd1);
`ifdef SCORE_EN
          w_score_inc = 1'b1;
`endif
          if (32'(r_round) + 32'd1 == ROUNDS_PER_LEVEL) begin
`ifdef SCORE_EN
            w_score_add = 32'(r_level) + 32'd1 + 32'(timer >> 2);
`endif
            if (32'(r_level) == LAST_LEVEL) begin
              w_state_nxt = S_WIN;
            end else begin
              w_state_nxt     = S_LOAD;
              w_level_nxt     = 3'(r_level + 3'd1);
              w_round_nxt     = 4'd0;
              w_incorrect_nxt = 4'd0;
            end
          end
        end else if (w_conf_p && !guess_correct) begin
          w_incorrect_nxt = 4'(r_incorrect + 4'd1);
          if (4'(r_incorrect + 4'd1) == w_max_inc_play) w_state_nxt = S_GAMEOVER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_new_game) begin
      w_state_nxt     = S_LOAD;
      w_level_nxt     = 3'd0;
      w_round_nxt     = 4'd0;
      w_incorrect_nxt = 4'd0;
`ifdef SCORE_EN
      w_score_nxt = '0;
`endif
    end

`ifdef SCORE_EN
    // Saturating accumulate of the per-guess award and any level bonus.
    if (w_score_inc) begin
      w_score_sum = 32'(r_score) + w_score_add;
      w_score_nxt = (w_score_sum > 32'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(w_score_sum);
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      r_state      <= S_IDLE;
      r_level      <= 3'd0;
      r_incorrect  <= 4'd0;
      r_round      <= 4'd0;
      r_confirm_q  <= 1'b0;
      r_timer_load <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_incorrect  <= w_incorrect_nxt;
      r_round      <= w_round_nxt;
      r_confirm_q  <= confirm;
      // High exactly during the LOAD cycle.
      r_timer_load <= (w_state_nxt == S_LOAD);
    end
  end

`ifdef SCORE_EN
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) r_score <= '0;
    else            r_score <= w_score_nxt;
  end
  assign score = r_score;
`endif

  assign level         = r_level;
  assign incorrect_cnt = r_incorrect;
  assign round_cnt     = r_round;
  assign timer_load    = r_timer_load;
  assign playing       = (r_state == S_PLAY);
  assign win           = (r_state == S_WIN);
  assign gameover      = (r_state == S_GAMEOVER);

endmodule

// File: tb/tb_game_level_fsm.sv
// Testbench for game_level_fsm: directed scenarios followed by randomized
// stimulus, all checked each cycle against a behavioural game model.
module tb_game_level_fsm;

  localparam int NL      = 3;
  localparam int RPL     = 5;
  localparam int BASE    = 3;
  localparam int TBASE   = 30;
  localparam int TW      = 7;
  localparam int TMAXV   = 127;
  localparam int SMAXV   = 1023;

  logic          clk = 1'b0;
  logic          restart_n;
  logic          start, confirm, guess_correct;
  logic [TW-1:0] timer;
  logic [2:0]    level;
  logic [3:0]    max_incorrect, max_digit, incorrect_cnt, round_cnt;
  logic          timer_load;
  logic [TW-1:0] timer_init;
  logic          playing, win, gameover;
`ifdef SCORE_EN
  logic [9:0]    score;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  game_level_fsm dut (
    .clk           (clk),
    .restart_n     (restart_n),
    .start         (start),
    .confirm       (confirm),
    .guess_correct (guess_correct),
    .timer         (timer),
    .level         (level),
    .max_incorrect (max_incorrect),
    .max_digit     (max_digit),
    .incorrect_cnt (incorrect_cnt),
    .round_cnt     (round_cnt),
    .timer_load    (timer_load),
    .timer_init    (timer_init),
    .playing       (playing),
    .win           (win),
    .gameover      (gameover)
`ifdef SCORE_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model of the game.
  typedef enum int {M_IDLE, M_LOAD, M_PLAY, M_WIN, M_OVER} mphase_t;
  mphase_t m_phase;
  int m_level, m_wrong, m_rounds, m_score;
  bit m_prev_conf, m_load;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_level = 0; m_wrong = 0; m_rounds = 0;
    m_score = 0; m_prev_conf = 0; m_load = 0;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > SMAXV) ? SMAXV : a + b;
  endfunction

  task automatic model_begin_game();
    m_phase = M_LOAD; m_level = 0; m_wrong = 0; m_rounds = 0; m_score = 0;
  endtask

  task automatic model_step();
    bit press;
    press = confirm && !m_prev_conf;
    m_prev_conf = confirm;
    case (m_phase)
      M_IDLE, M_WIN, M_OVER: if (start) model_begin_game();
      M_LOAD: m_phase = M_PLAY;
      M_PLAY: begin
        if (timer == 0) m_phase = M_OVER;
        else if (press && guess_correct) begin
          m_rounds++;
          m_score = sat_add(m_score, m_level + 1);
          if (m_rounds == RPL) begin
            m_score = sat_add(m_score, int'(timer) / 4);
            if (m_level == NL - 1) m_phase = M_WIN;
            else begin
              m_level++; m_rounds = 0; m_wrong = 0; m_phase = M_LOAD;
            end
          end
        end else if (press) begin
          m_wrong++;
          if (m_wrong == BASE + m_level) m_phase = M_OVER;
        end
      end
      default: m_phase = M_IDLE;
    endcase
    m_load = (m_phase == M_LOAD);
  endtask

  task automatic check_all();
    bit active;
    int ti;
    active = (m_phase == M_IDLE || m_phase == M_LOAD || m_phase == M_PLAY);
    ti = TBASE * (m_level + 1);
    if (ti > TMAXV) ti = TMAXV;
    chk("level",         32'(level),         32'(m_level));
    chk("max_incorrect", 32'(max_incorrect), active ? 32'(BASE + m_level) : 32'd0);
    chk("max_digit",     32'(max_digit),     active ? 32'(m_level + 1) : 32'd0);
    chk("incorrect_cnt", 32'(incorrect_cnt), 32'(m_wrong));
    chk("round_cnt",     32'(round_cnt),     32'(m_rounds));
    chk("timer_load",    32'(timer_load),    32'(m_load));
    chk("timer_init",    32'(timer_init),    32'(ti));
    chk("playing",       32'(playing),       32'(m_phase == M_PLAY));
    chk("win",           32'(win),           32'(m_phase == M_WIN));
    chk("gameover",      32'(gameover),      32'(m_phase == M_OVER));
`ifdef SCORE_EN
    chk("score",         32'(score),         32'(m_score));
`endif
  endtask

  // One clock with the given inputs; called at a negedge.
  task automatic tick(input bit st, input bit cf, input bit gc, input int tm);
    start = st; confirm = cf; guess_correct = gc; timer = TW'(tm);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic guess(input bit gc, input int tm);
    tick(0, 1, gc, tm);
    tick(0, 0, gc, tm);
  endtask

  initial begin
    restart_n = 1'b0; start = 0; confirm = 0; guess_correct = 0; timer = TW'(100);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_max_incorrect", 32'(max_incorrect), 32'd3);
    restart_n = 1'b1;
    tick(0, 0, 0, 100);

    // Clear level 0 with timer=20.
    tick(1, 0, 0, 100);
    chk("load0_strobe", 32'(timer_load), 32'd1);
    chk("load0_init",   32'(timer_init), 32'd30);
    tick(0, 0, 0, 20);
    for (int i = 0; i < RPL; i++) guess(1, 20);
    // The last guess() added a trailing idle tick; step back to see the LOAD cycle.
    // Instead, verify level-1 values now in PLAY and rely on per-cycle model for the strobe.
    chk("lvl1_level",   32'(level),         32'd1);
    chk("lvl1_init",    32'(timer_init),    32'd60);
    chk("lvl1_maxinc",  32'(max_incorrect), 32'd4);
    chk("lvl1_maxdig",  32'(max_digit),     32'd2);

    // Asynchronous reset mid-PLAY at level 1.
    chk("lvl1_playing", 32'(playing), 32'd1);
    #2 restart_n = 1'b0;
    #1;
    chk("arst_level",   32'(level),         32'd0);
    chk("arst_round",   32'(round_cnt),     32'd0);
    chk("arst_wrong",   32'(incorrect_cnt), 32'd0);
    chk("arst_tload",   32'(timer_load),    32'd0);
    chk("arst_playing", 32'(playing),       32'd0);
    model_reset();
    @(negedge clk);
    restart_n = 1'b1;
    check_all();

    // Three wrong guesses at level 0.
    tick(1, 0, 0, 50);
    tick(0, 0, 0, 50);
    for (int i = 0; i < BASE; i++) guess(0, 50);
    chk("go_wrong",    32'(incorrect_cnt), 32'd3);
    chk("go_maxinc",   32'(max_incorrect), 32'd0);
    chk("go_flag",     32'(gameover),      32'd1);
    tick(1, 0, 0, 50);
    chk("restart_level", 32'(level),      32'd0);
    chk("restart_load",  32'(timer_load), 32'd1);

    // Play through to WIN; at level 2 one guess is held for 10 cycles.
    tick(0, 0, 0, 40);
    for (int l = 0; l < NL - 1; l++) begin
      for (int i = 0; i < RPL; i++) guess(1, 40);
      tick(0, 0, 0, 40);
    end
    for (int i = 0; i < 10; i++) tick(0, 1, 1, 40);
    tick(0, 0, 1, 40);
    chk("held_once", 32'(round_cnt), 32'd1);
    for (int i = 1; i < RPL; i++) guess(1, 40);
    chk("win_flag",  32'(win),   32'd1);
    chk("win_level", 32'(level), 32'd2);

    // Timeout beats a simultaneous correct guess.
    tick(1, 0, 0, 40);
    tick(0, 0, 0, 40);
    guess(1, 40);
    tick(0, 1, 1, 0);
    chk("tmo_over",  32'(gameover),  32'd1);
    chk("tmo_round", 32'(round_cnt), 32'd1);
    tick(0, 0, 0, 0);

`ifdef SCORE_EN
    tick(1, 0, 0, 20);
    tick(0, 0, 0, 20);
    for (int i = 0; i < RPL; i++) guess(1, 20);
    chk("score_l0", 32'(score), 32'd10);
    tick(0, 0, 0, 20);
    guess(1, 20);
    chk("score_l1_guess", 32'(score), 32'd12);
    for (int i = 1; i < RPL - 1; i++) guess(1, 20);
    guess(1, 40);
    chk("score_l1_clear", 32'(score), 32'd30);
`endif

    // Randomized play, with occasional mid-cycle resets.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 restart_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        restart_n = 1'b1;
        check_all();
      end else begin
        tick($urandom_range(0, 7) == 0,
             1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 9,
             ($urandom_range(0, 99) == 0) ? 0 : int'($urandom_range(1, 127)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
